// File: rtl/fb_arbiter_pkg.sv
// fb_arbiter shared types: issue states, default widths, write-buffer entry.
// Imported by the interface, the write buffer and the arbiter top.
package fb_arb_pkg;

   localparam int FB_ADDR_W = 19;
   localparam int FB_DATA_W = 8;

   typedef enum logic [1:0] {
      ISS_IDLE = 2'd0,
      ISS_RD   = 2'd1,
      ISS_WR   = 2'd2
   } issue_state_t;

   typedef struct packed {
      logic [FB_ADDR_W-1:0] addr;
      logic [FB_DATA_W-1:0] data;
   } wb_entry_t;

endpackage

// File: rtl/fb_arbiter_if.sv
// Framebuffer arbiter bus bundle: scanout read, ASIP write, RAM port, status.
// slave = arbiter side, master = requester/RAM/environment side.
interface fb_arbiter_if #(
   parameter int ADDR_W  = 19,
   parameter int DATA_W  = 8,
   parameter int STALL_W = 16
);
   logic              rd_req;
   logic [ADDR_W-1:0] rd_addr;
   logic              rd_valid;
   logic [DATA_W-1:0] rd_data;
   logic              wr_valid;
   logic              wr_ready;
   logic [ADDR_W-1:0] wr_addr;
   logic [DATA_W-1:0] wr_data;
   logic              vblank;
   logic              mem_en;
   logic              mem_we;
   logic [ADDR_W-1:0] mem_addr;
   logic [DATA_W-1:0] mem_wdata;
   logic [DATA_W-1:0] mem_rdata;
   logic              wbuf_empty;
   logic [STALL_W-1:0] stall_cnt;

   modport slave (
      input  rd_req, rd_addr, wr_valid, wr_addr, wr_data, vblank, mem_rdata,
      output rd_valid, rd_data, wr_ready, mem_en, mem_we, mem_addr,
      output mem_wdata, wbuf_empty, stall_cnt
   );

   modport master (
      output rd_req, rd_addr, wr_valid, wr_addr, wr_data, vblank, mem_rdata,
      input  rd_valid, rd_data, wr_ready, mem_en, mem_we, mem_addr,
      input  mem_wdata, wbuf_empty, stall_cnt
   );
endinterface

// File: rtl/fb_arbiter_wbuf.sv
// fb_wbuf: in-order write buffer FIFO of wb_entry_t, no bypass.
// Full/empty decode straight from the occupancy register.
module fb_wbuf
   import fb_arb_pkg::*;
#(
   parameter int DEPTH = 4
) (
   input  logic      clk,
   input  logic      reset,
   input  logic      i_push,
   input  wb_entry_t i_din,
   input  logic      i_pop,
   output wb_entry_t o_head,
   output logic      o_full,
   output logic      o_empty
);
   localparam int PW = $clog2(DEPTH);

   logic [PW-1:0] r_wptr;
   logic [PW-1:0] r_rptr;
   logic [PW:0]   r_cnt;
   wb_entry_t     r_mem [DEPTH];
   logic          w_push;
   logic          w_pop;

   // DEPTH is a power of two, so the count MSB alone means full
   assign o_full  = r_cnt[PW];
   assign o_empty = (r_cnt == '0);
   assign o_head  = r_mem[r_rptr];
   assign w_push  = i_push & ~o_full;
   assign w_pop   = i_pop & ~o_empty;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_wptr <= '0;
         r_rptr <= '0;
         r_cnt  <= '0;
      end else begin
         if (w_push) r_wptr <= r_wptr + PW'(1);
         if (w_pop)  r_rptr <= r_rptr + PW'(1);
         r_cnt <= r_cnt + (PW+1)'(w_push) - (PW+1)'(w_pop);
      end
   end

   always_ff @(posedge clk) begin
      if (w_push) r_mem[r_wptr] <= i_din;
   end

endmodule

// File: rtl/fb_arbiter.sv
// Framebuffer RAM arbiter: scanout reads win, ASIP writes drain when idle.
// FB_VBLANK_WR_EN: when defined, writes issue only while vblank is high.
module fb_arbiter
   import fb_arb_pkg::*;
#(
   parameter int ADDR_W     = FB_ADDR_W,
   parameter int DATA_W     = FB_DATA_W,
   parameter int WBUF_DEPTH = 4,
   parameter int STALL_W    = 16
) (
   input  logic        clk,
   input  logic        reset,
   fb_arbiter_if.slave bus
);
   issue_state_t       r_state;
   issue_state_t       w_next;
   logic [ADDR_W-1:0]  r_addr;
   logic [DATA_W-1:0]  r_wdata;
   logic               r_rd_d;
   logic               r_rd_valid;
   logic [DATA_W-1:0]  r_rd_data;
   logic [STALL_W-1:0] r_stall;
   logic               w_wr_ok;
   logic               w_full;
   logic               w_empty;
   logic               w_push;
   logic               w_pop;
   wb_entry_t          w_din;
   wb_entry_t          w_head;

`ifdef FB_VBLANK_WR_EN
   assign w_wr_ok = bus.vblank;
`else
   logic w_unused_vblank;
   assign w_unused_vblank = bus.vblank;
   assign w_wr_ok = 1'b1;
`endif

   always_comb begin
      w_next = ISS_IDLE;
      if (bus.rd_req)
         w_next = ISS_RD;
      else if (!w_empty && w_wr_ok)
         w_next = ISS_WR;
   end

   assign w_pop  = (w_next == ISS_WR);
   assign w_push = bus.wr_valid & ~w_full;
   assign w_din  = '{addr: FB_ADDR_W'(bus.wr_addr),
                     data: FB_DATA_W'(bus.wr_data)};

   fb_wbuf #(.DEPTH(WBUF_DEPTH)) u_wbuf (
      .clk     (clk),
      .reset   (reset),
      .i_push  (w_push),
      .i_din   (w_din),
      .i_pop   (w_pop),
      .o_head  (w_head),
      .o_full  (w_full),
      .o_empty (w_empty)
   );

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state    <= ISS_IDLE;
         r_addr     <= '0;
         r_wdata    <= '0;
         r_rd_d     <= 1'b0;
         r_rd_valid <= 1'b0;
         r_rd_data  <= '0;
         r_stall    <= '0;
      end else begin
         r_state <= w_next;
         if (w_next == ISS_RD) begin
            r_addr <= bus.rd_addr;
         end else if (w_next == ISS_WR) begin
            r_addr  <= ADDR_W'(w_head.addr);
            r_wdata <= DATA_W'(w_head.data);
         end
         // RAM answers one cycle after the command; register it once more
         r_rd_d     <= (r_state == ISS_RD);
         r_rd_valid <= r_rd_d;
         r_rd_data  <= bus.mem_rdata;
         if (!w_empty && w_next != ISS_WR && r_stall != '1)
            r_stall <= r_stall + STALL_W'(1);
      end
   end

   assign bus.mem_en     = (r_state != ISS_IDLE);
   assign bus.mem_we     = (r_state == ISS_WR);
   assign bus.mem_addr   = r_addr;
   assign bus.mem_wdata  = r_wdata;
   assign bus.rd_valid   = r_rd_valid;
   assign bus.rd_data    = r_rd_data;
   assign bus.wr_ready   = ~w_full;
   assign bus.wbuf_empty = w_empty;
   assign bus.stall_cnt  = r_stall;

endmodule

// File: tb/tb_fb_arbiter.sv
// Scoreboard bench for fb_arbiter with a behavioural single-port RAM.
// Covers FB_VBLANK_WR_EN when that macro is defined for the build.
module tb_fb_arbiter;
   import fb_arb_pkg::*;

   localparam int AW = 19;
   localparam int DW = 8;

   logic clk = 1'b0;
   logic reset = 1'b1;
   always #5 clk = ~clk;

   fb_arbiter_if #(.ADDR_W(AW), .DATA_W(DW), .STALL_W(16)) bif ();

   fb_arbiter #(
      .ADDR_W(AW), .DATA_W(DW), .WBUF_DEPTH(4), .STALL_W(16)
   ) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bif)
   );

   logic [DW-1:0] ram [0:(1<<AW)-1];
   always @(posedge clk) begin
      if (bif.mem_en) begin
         if (bif.mem_we) ram[bif.mem_addr] <= bif.mem_wdata;
         else bif.mem_rdata <= ram[bif.mem_addr];
      end
   end

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int n_chk = 0;
   int n_pass = 0;

   task automatic chk(input string name, input logic [31:0] act,
                      input logic [31:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h (cycle %0d)",
                    name, act, exp, cyc);
   endtask

   typedef struct { logic [DW-1:0] d; int due; } rexp_t;
   typedef struct { logic [AW-1:0] a; logic [DW-1:0] d; } wexp_t;
   rexp_t rq[$];
   wexp_t wq[$];

   // Monitor: pop and compare whenever the DUT presents a read or a write
   always @(negedge clk) begin
      if (!reset) begin
         if (bif.rd_valid) begin
            chk("rd_expected", 32'(rq.size() != 0), 1);
            if (rq.size() != 0) begin
               rexp_t r;
               r = rq.pop_front();
               chk("rd_data", 32'(bif.rd_data), 32'(r.d));
               chk("rd_latency", cyc, r.due);
            end
         end
         if (bif.mem_en && bif.mem_we) begin
            chk("wr_expected", 32'(wq.size() != 0), 1);
            if (wq.size() != 0) begin
               wexp_t w;
               w = wq.pop_front();
               chk("wr_addr", 32'(bif.mem_addr), 32'(w.a));
               chk("wr_data", 32'(bif.mem_wdata), 32'(w.d));
            end
         end
      end
   end

   task automatic chk_reset();
      chk("rst_mem_en", 32'(bif.mem_en), 0);
      chk("rst_mem_we", 32'(bif.mem_we), 0);
      chk("rst_mem_addr", 32'(bif.mem_addr), 0);
      chk("rst_mem_wdata", 32'(bif.mem_wdata), 0);
      chk("rst_rd_valid", 32'(bif.rd_valid), 0);
      chk("rst_wr_ready", 32'(bif.wr_ready), 1);
      chk("rst_wbuf_empty", 32'(bif.wbuf_empty), 1);
      chk("rst_stall_cnt", 32'(bif.stall_cnt), 0);
   endtask

   task automatic do_reset();
      @(negedge clk);
      bif.rd_req = 1'b0;
      bif.wr_valid = 1'b0;
      reset = 1'b1;
      #1 chk_reset();
      @(negedge clk);
      reset = 1'b0;
   endtask

   logic [AW-1:0] wa [5];
   logic [DW-1:0] wd [5];
   int idx;
   int we_seen;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      bif.rd_req = 1'b0;
      bif.rd_addr = '0;
      bif.wr_valid = 1'b0;
      bif.wr_addr = '0;
      bif.wr_data = '0;
`ifdef FB_VBLANK_WR_EN
      bif.vblank = 1'b1;
`else
      bif.vblank = 1'b0;
`endif
      ram[19'h00010] = 8'h77;
      ram[19'h00123] = 8'hA5;
      for (int i = 0; i < 10; i++) ram[19'h01000 + 19'(i)] = 8'h40 + 8'(i);
      wa[0] = 19'h00300; wd[0] = 8'h11;
      wa[1] = 19'h00301; wd[1] = 8'h22;
      wa[2] = 19'h00302; wd[2] = 8'h33;
      wa[3] = 19'h00303; wd[3] = 8'h44;
      wa[4] = 19'h00304; wd[4] = 8'h55;

      repeat (3) @(negedge clk);
      chk_reset();
      reset = 1'b0;

      // reset mid-read: the in-flight rd_valid must never appear
      @(negedge clk);
      bif.rd_req = 1'b1;
      bif.rd_addr = 19'h00010;
      @(negedge clk);
      bif.rd_req = 1'b0;
      @(negedge clk);
      reset = 1'b1;
      #1 chk_reset();
      @(negedge clk);
      reset = 1'b0;
      repeat (5) @(negedge clk);

      // single read, latency 2 edges after the sampling edge
      bif.rd_req = 1'b1;
      bif.rd_addr = 19'h00123;
      rq.push_back('{8'hA5, cyc + 3});
      @(negedge clk);
      bif.rd_req = 1'b0;
      repeat (4) @(negedge clk);

      // single write with idle reader, then read it back
      bif.wr_valid = 1'b1;
      bif.wr_addr = 19'h00200;
      bif.wr_data = 8'h3C;
      wq.push_back('{19'h00200, 8'h3C});
      @(negedge clk);
      bif.wr_valid = 1'b0;
      @(negedge clk);
      chk("single_wr_we", 32'(bif.mem_we), 1);
      chk("single_wr_addr", 32'(bif.mem_addr), 32'h200);
      bif.rd_req = 1'b1;
      bif.rd_addr = 19'h00200;
      rq.push_back('{8'h3C, cyc + 3});
      @(negedge clk);
      bif.rd_req = 1'b0;
      repeat (4) @(negedge clk);

      // read storm of 10 cycles with 5 writes offered, then drain
      do_reset();
      idx = 0;
      we_seen = 0;
      for (int t = 0; t < 22; t++) begin
         @(negedge clk);
         if (t >= 1 && t <= 11 && bif.mem_we) we_seen++;
         if (t == 4) chk("storm_wr_ready", 32'(bif.wr_ready), 0);
         if (t == 11) chk("storm_stall", 32'(bif.stall_cnt), 10);
         bif.rd_req = (t >= 1 && t <= 10);
         bif.rd_addr = 19'h01000 + 19'(t - 1);
         if (bif.rd_req) rq.push_back('{8'h40 + 8'(t - 1), cyc + 3});
         if (idx < 5) begin
            bif.wr_valid = 1'b1;
            bif.wr_addr = wa[idx];
            bif.wr_data = wd[idx];
            if (bif.wr_ready) begin
               wq.push_back('{wa[idx], wd[idx]});
               idx++;
            end
         end else begin
            bif.wr_valid = 1'b0;
         end
      end
      chk("storm_no_we", 32'(we_seen), 0);
      chk("storm_all_accepted", 32'(idx), 5);
      chk("drain_empty", 32'(bif.wbuf_empty), 1);
      chk("drain_stall", 32'(bif.stall_cnt), 10);

`ifdef FB_VBLANK_WR_EN
      // writes held off by vblank=0 count as stalls
      do_reset();
      bif.vblank = 1'b0;
      idx = 0;
      we_seen = 0;
      for (int t = 0; t < 26; t++) begin
         @(negedge clk);
         if (t >= 1 && t <= 21 && bif.mem_we) we_seen++;
         if (t == 21) begin
            chk("vblank_stall", 32'(bif.stall_cnt), 20);
            bif.vblank = 1'b1;
         end
         if (t == 23) chk("vblank_wr2_we", 32'(bif.mem_we), 1);
         if (idx < 2) begin
            bif.wr_valid = 1'b1;
            bif.wr_addr = wa[idx];
            bif.wr_data = wd[idx];
            wq.push_back('{wa[idx], wd[idx]});
            idx++;
         end else begin
            bif.wr_valid = 1'b0;
         end
      end
      chk("vblank_no_we", 32'(we_seen), 0);
      chk("vblank_empty", 32'(bif.wbuf_empty), 1);
`endif

      for (int i = 0; i < 50 && (rq.size() != 0 || wq.size() != 0); i++)
         @(negedge clk);
      chk("rq_drained", rq.size(), 0);
      chk("wq_drained", wq.size(), 0);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule

// File: doc/fb_arbiter.md
Name: fb_arbiter

Overview:
Arbitrates a single-port synchronous framebuffer RAM between two requesters:
- the VGA scanout reader (videoGen pixel fetch), which needs fixed read latency;
- the ASIP vector-store writer, which is elastic.

Reads always win. Writes are absorbed into a small in-order write buffer and drained on idle memory cycles. The block sits between the ASIP store unit, the vga pixel path and the framebuffer RAM, all in the clk domain.

Parameters:
ADDR_W, 19, framebuffer word address width (640x480 pixels)
DATA_W, 8, pixel word width
WBUF_DEPTH, 4, write buffer entries; power of 2, >= 2
STALL_W, 16, width of the write-stall counter

Ports:
clk  in  1  system clock
reset  in  1  asynchronous active-high reset
rd_req  in  1  scanout read request, single-cycle strobe, may repeat every cycle
rd_addr  in  ADDR_W  read address, sampled with rd_req
rd_valid  out  1  read data valid strobe
rd_data  out  DATA_W  read data
wr_valid  in  1  writer presents a write
wr_ready  out  1  write buffer can accept
wr_addr  in  ADDR_W  write address
wr_data  in  DATA_W  write data
vblank  in  1  vertical blanking flag, clk domain; used only with the optional feature
mem_en  out  1  RAM enable
mem_we  out  1  RAM write enable
mem_addr  out  ADDR_W  RAM address
mem_wdata  out  DATA_W  RAM write data
mem_rdata  in  DATA_W  RAM read data, valid one cycle after a read command
wbuf_empty  out  1  write buffer empty
stall_cnt  out  STALL_W  cycles a buffered write was blocked

Behaviour:
- Reset values: mem_en=0, mem_we=0, mem_addr=0, mem_wdata=0, rd_valid=0, wr_ready=1, wbuf_empty=1, stall_cnt=0. Write buffer is emptied.
- Reset mid-operation: buffered writes are discarded. A pending rd_valid is dropped and does not appear after reset release.
- Issue FSM: one registered command per cycle.
  - States: ISS_IDLE, ISS_RD, ISS_WR. The state equals the command currently driven on the mem_* outputs.
  - Next state = ISS_RD if rd_req; else ISS_WR if the buffer is non-empty (and writes are permitted); else ISS_IDLE.
- ISS_RD: mem_en=1, mem_we=0, mem_addr = rd_addr registered.
- ISS_WR: mem_en=1, mem_we=1, mem_addr/mem_wdata = buffer head. The head is popped on the edge that enters ISS_WR.
- ISS_IDLE: mem_en=0, mem_we=0. mem_addr and mem_wdata hold their previous values.
- Read latency: rd_req sampled at edge k gives rd_valid=1 for exactly one cycle after edge k+2.
  - rd_data equals the registered mem_rdata for that cycle.
  - Back-to-back reads give back-to-back rd_valid, with no bubbles.
- Write buffer:
  - Push on wr_valid & wr_ready.
  - wr_ready = !full, registered.
  - Full: wr_ready=0 and wr_valid is ignored.
  - No bypass: an entry pushed at edge k is first eligible for pop at edge k+1.
  - Push and pop on the same edge are both honoured; the occupancy count is unchanged.
- Ordering: writes reach RAM in acceptance order.
- No read-after-write forwarding: a read of an address with a pending buffered write returns the RAM contents as they stand.
- Starvation: continuous rd_req blocks writes indefinitely, by design. Scanout never stalls.
- stall_cnt increments on every edge where the buffer is non-empty and no write is issued.
  - Saturates at all-ones.
  - Cleared only by reset.
- Pointers wrap modulo WBUF_DEPTH. The occupancy count is log2(WBUF_DEPTH)+1 bits wide.

Optional Feature:
FB_VBLANK_WR_EN:
- Defined: a write is issued only when vblank=1, giving tear-free updates. Cycles blocked by vblank=0 count toward stall_cnt.
- Undefined: vblank is ignored and writes drain on any free cycle.

Decomposition:
- Package fb_arb_pkg: issue_state_t enum (ISS_IDLE, ISS_RD, ISS_WR), default ADDR_W/DATA_W constants, wb_entry_t struct {addr, data}.
- Sub-module fb_wbuf: synchronous FIFO of wb_entry_t, depth WBUF_DEPTH, with push/pop/full/empty.

Test Plan:
- Reset mid-read: rd_req at addr 0x00010, assert reset 1 cycle later -> no rd_valid afterwards; all outputs at reset values; wr_ready=1.
- Single read: RAM[0x00123]=0xA5, rd_req at edge k -> rd_valid only after edge k+2, rd_data=0xA5.
- Single write, idle reader: wr_valid with addr 0x00200, data 0x3C -> mem_we=1, mem_addr=0x00200 one cycle later; a subsequent read returns 0x3C.
- Buffer full under read storm: rd_req held high 10 cycles while 5 writes are offered (WBUF_DEPTH=4) -> wr_ready=0 after the 4th write; zero mem_we cycles during the storm; stall_cnt=10.
- Ordering and drain: after the storm, rd_req low -> 4 consecutive ISS_WR cycles in push order; the 5th write is then accepted and issued; wbuf_empty=1 at the end.
- With FB_VBLANK_WR_EN: 2 writes buffered, vblank=0 for 20 cycles -> no mem_we and stall_cnt=20; vblank=1 -> both writes issued on the next 2 cycles.
